// File: rtl/ramcard_ctrl.sv
// Apple II slot RAM card controller: bus-cycle sequencer, address/bank registers,
// DRAM RAS/CAS timing with CAS-before-RAS refresh, and slot ROM select.
module ramcard_ctrl #(
  parameter int unsigned RA_W    = 11,
  parameter int unsigned CS_W    = 1,
  parameter int unsigned BANK_W  = 7,
  parameter int unsigned REF_DIV = 13
) (
  input  logic                 C7M,
  input  logic                 nRES,
  input  logic                 PHI1,
  input  logic                 nDEVSEL,
  input  logic                 nIOSEL,
  input  logic                 nIOSTRB,
  input  logic [11:0]          A,
  input  logic                 nWE,
  input  logic [7:0]           Din,
  input  logic [7:0]           RDin,
  output logic [7:0]           Dout,
  output logic                 DOE,
  output logic                 RDOE,
  output logic [RA_W-1:0]      RA,
  output logic                 nRAS,
  output logic [2**CS_W-1:0]   nCAS,
  output logic                 nRCS
);

  localparam int unsigned ADDR_W  = 2 * RA_W + CS_W;
  localparam int unsigned NUM_CAS = 2 ** CS_W;

  logic [2:0]          s_q, s_d;
  logic                phi1_q, phi0seen_q, phi0seen_d;
  logic                csdben_q, csdben_d;
  logic                regen_q, regen_d;
  logic                ioromen_q, ioromen_d;
  logic                ramsel_q, ramsel_d;
  logic                asel_q, asel_d;
  logic                refcyc_q, refcyc_d;
  logic [3:0]          ref_q, ref_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic                inc_en_q, inc_en_d;
  logic                dir_q, dir_d;
  logic                nras_q, nras_d;
  logic [NUM_CAS-1:0]  ncas_q, ncas_d;

  logic                sync, at_s4, ramsel_now, reg_wr;
  logic [ADDR_W-1:0]   cas_sel;

  always_comb begin
    sync       = PHI1 & ~phi1_q & phi0seen_q;
    at_s4      = (s_q == 3'd4);
    ramsel_now = (A[3:0] == 4'h3) & ~nDEVSEL & regen_q;
    reg_wr     = (s_q == 3'd6) & ~nWE & ~nDEVSEL & regen_q;

    // S parks at 0 (never synced) or 7 (waiting for the next PHI1 rise).
    if (sync)                          s_d = 3'd1;
    else if (s_q == 3'd0 || s_q == 3'd7) s_d = s_q;
    else                               s_d = s_q + 3'd1;

    phi0seen_d = phi0seen_q | ~PHI1;
    csdben_d   = s_q[2];
    regen_d    = regen_q | (at_s4 & ~nIOSEL);

    ioromen_d = ioromen_q;
    if (at_s4 & ~nIOSEL) ioromen_d = 1'b1;
    if ((s_q == 3'd3) & ~nIOSTRB & (A[10:0] == 11'h7FF)) ioromen_d = 1'b0;

    ramsel_d = at_s4 ? ramsel_now : ramsel_q;
    asel_d   = at_s4 & ramsel_now;
    refcyc_d = sync ? (ref_q == 4'd0) : refcyc_q;
    ref_d    = ref_q;
    if (at_s4) ref_d = (ref_q == 4'(REF_DIV - 1)) ? 4'd0 : ref_q + 4'd1;

    addr_d   = addr_q;
    bank_d   = bank_q;
    inc_en_d = inc_en_q;
    dir_d    = dir_q;
    if ((s_q == 3'd1) & ramsel_q & inc_en_q) begin
      addr_d = dir_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
    end
    if (reg_wr) begin
      unique case (A[3:0])
        4'h0:    addr_d[7:0]         = Din;
        4'h1:    addr_d[15:8]        = Din;
        4'h2:    addr_d[ADDR_W-1:16] = Din[ADDR_W-17:0];
        4'h4:    {dir_d, inc_en_d}   = Din[1:0];
        4'hF:    bank_d              = Din[BANK_W-1:0];
        default: ;
      endcase
    end

    // Strobes are decoded from next state so they toggle only on the clock edge.
    cas_sel = addr_d >> (2 * RA_W);
    nras_d  = ~((refcyc_d & (s_d == 3'd2 || s_d == 3'd3)) |
                (ramsel_d & (s_d == 3'd5 || s_d == 3'd6)));
    for (int i = 0; i < int'(NUM_CAS); i++) begin
      ncas_d[i] = ~((refcyc_d & (s_d == 3'd1 || s_d == 3'd2)) |
                    (ramsel_d & ~nDEVSEL & (s_d == 3'd6 || s_d == 3'd7) &
                     (cas_sel == ADDR_W'(i))));
    end
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      s_q        <= 3'd0;
      phi1_q     <= 1'b0;
      phi0seen_q <= 1'b0;
      csdben_q   <= 1'b0;
      regen_q    <= 1'b0;
      ioromen_q  <= 1'b0;
      ramsel_q   <= 1'b0;
      asel_q     <= 1'b0;
      refcyc_q   <= 1'b0;
      ref_q      <= 4'd0;
      addr_q     <= '0;
      bank_q     <= '0;
      inc_en_q   <= 1'b1;
      dir_q      <= 1'b0;
      nras_q     <= 1'b1;
      ncas_q     <= '1;
    end else begin
      s_q        <= s_d;
      phi1_q     <= PHI1;
      phi0seen_q <= phi0seen_d;
      csdben_q   <= csdben_d;
      regen_q    <= regen_d;
      ioromen_q  <= ioromen_d;
      ramsel_q   <= ramsel_d;
      asel_q     <= asel_d;
      refcyc_q   <= refcyc_d;
      ref_q      <= ref_d;
      addr_q     <= addr_d;
      bank_q     <= bank_d;
      inc_en_q   <= inc_en_d;
      dir_q      <= dir_d;
      nras_q     <= nras_d;
      ncas_q     <= ncas_d;
    end
  end

  logic [7:0] addrh_rd;

  always_comb begin
    addrh_rd                = 8'hFF;
    addrh_rd[ADDR_W-17:0]   = addr_q[ADDR_W-1:16];
    Dout                    = 8'h00;
    if (!nIOSEL || !nIOSTRB) begin
      Dout = RDin;
    end else begin
      unique case (A[3:0])
        4'h0:    Dout = addr_q[7:0];
        4'h1:    Dout = addr_q[15:8];
        4'h2:    Dout = addrh_rd;
        4'h3:    Dout = RDin;
        4'h4:    Dout = {6'b0, dir_q, inc_en_q};
        4'hF:    Dout = 8'(bank_q);
        default: Dout = 8'h00;
      endcase
    end

    DOE  = nRES & csdben_q & nWE &
           ((~nDEVSEL & regen_q) | ~nIOSEL | (~nIOSTRB & ioromen_q));
    RDOE = csdben_q & ~nWE & (~nDEVSEL | ~nIOSEL | ~nIOSTRB);
    nRCS = ~(csdben_q & (~nIOSEL | (~nIOSTRB & ioromen_q)));

    if (!nDEVSEL) RA = asel_q ? addr_q[RA_W-1:0] : addr_q[2*RA_W-1:RA_W];
    else          RA = RA_W'({bank_q, A[11]});
  end

  assign nRAS = nras_q;
  assign nCAS = ncas_q;

endmodule
